// File: rtl/cpu_core.sv
// cpu_core: parametrised fetch/execute CPU for the 16-bit opcode/Rd/Rn/Rm ISA.
// Reads a synchronous instruction memory, talks to a req/ack data memory,
// reports OUT through a one-cycle strobe, and stops in a sticky halt state.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   imem_addr           instruction address (always the current pc)
//   imem_rdata          instruction word, valid the cycle after imem_addr
//   dmem_req/we/addr/wdata  data request, held stable until dmem_ack
//   dmem_rdata/ack      load data and one-cycle completion pulse
//   out_valid/out_data  OUT strobe and the register value it carries
//   halted              high once HALT executes, until rst
//   carry               carry/borrow flag
module cpu_core #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               halted,
    output logic               carry
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'h0, OP_ADDI = 4'h1, OP_SUB  = 4'h2, OP_SUBI = 4'h3,
                           OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_OUT  = 4'h7,
                           OP_NAND = 4'h8, OP_HALT = 4'h9, OP_LSL  = 4'hA, OP_BL   = 4'hB,
                           OP_BEQ  = 4'hC, OP_BR   = 4'hD, OP_STUR = 4'hE, OP_LDUR = 4'hF;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 carry_q, carry_d;
    logic [DATA_W-1:0]    regs_q [16];
    logic [DATA_W-1:0]    regs_d [16];
    logic                 mem_we_q, mem_we_d;
    logic [DADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [3:0]           ld_reg_q, ld_reg_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;

    logic [3:0]           op, rd, rn, rm;
    logic [DATA_W-1:0]    rd_val, rn_val, rm_val, operand_b;
    logic [DATA_W:0]      add_res, sub_res;
    logic [PC_W-1:0]      pc_inc;
    logic                 rf_we;
    logic [3:0]           rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;

    // The instruction register is the memory's own output register: imem_rdata
    // is decoded directly during EXEC, and MEM keeps what it needs in mem_*_q.
    always_comb begin
        {op, rd, rn, rm} = imem_rdata;
        rd_val    = regs_q[rd];
        rn_val    = regs_q[rn];
        rm_val    = regs_q[rm];
        operand_b = (op == OP_ADDI || op == OP_SUBI) ? DATA_W'(rm) : rm_val;
        add_res   = {1'b0, rn_val} + {1'b0, operand_b};
        // The extra top bit of the subtraction is the unsigned borrow.
        sub_res   = {1'b0, rn_val} - {1'b0, operand_b};
        pc_inc    = pc_q + PC_W'(1);
    end

    // State register: every flop, including the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            carry_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_reg_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            carry_q     <= carry_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_reg_q    <= ld_reg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Next-state logic: FSM transitions plus the single register write port.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        carry_d     = carry_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_reg_d    = ld_reg_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        rf_we       = 1'b0;
        rf_waddr    = rd;
        rf_wdata    = '0;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_ADD, OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = add_res[DATA_W-1:0];
                        carry_d  = add_res[DATA_W];
                    end
                    OP_SUB, OP_SUBI: begin
                        rf_we    = 1'b1;
                        rf_wdata = sub_res[DATA_W-1:0];
                        carry_d  = sub_res[DATA_W];
                    end
                    OP_AND:  begin rf_we = 1'b1; rf_wdata = rn_val & rm_val;    end
                    OP_OR:   begin rf_we = 1'b1; rf_wdata = rn_val | rm_val;    end
                    OP_XOR:  begin rf_we = 1'b1; rf_wdata = rn_val ^ rm_val;    end
                    OP_NAND: begin rf_we = 1'b1; rf_wdata = ~(rn_val & rm_val); end
                    // A 4-bit count at or beyond DATA_W shifts everything out.
                    OP_LSL:  begin rf_we = 1'b1; rf_wdata = rn_val << rm;       end
                    OP_OUT: begin
                        out_valid_d = 1'b1;
                        out_data_d  = rd_val;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    // Target comes from the pre-write R15, so BL R15 uses the old link.
                    OP_BL: begin
                        pc_d     = PC_W'(rd_val);
                        rf_we    = 1'b1;
                        rf_waddr = 4'hF;
                        rf_wdata = DATA_W'(pc_inc);
                    end
                    OP_BEQ: if (rn_val == rm_val) pc_d = PC_W'(rd_val);
                    OP_BR:  pc_d = PC_W'(rd_val);
                    OP_STUR, OP_LDUR: begin
                        state_d     = S_MEM;
                        pc_d        = pc_q;
                        mem_we_d    = (op == OP_STUR);
                        mem_addr_d  = DADDR_W'(rd_val);
                        mem_wdata_d = rn_val;
                        ld_reg_d    = rn;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d  = S_FETCH;
                    pc_d     = pc_inc;
                    rf_we    = !mem_we_q;
                    rf_waddr = ld_reg_q;
                    rf_wdata = dmem_rdata;
                end
            end
            default: ;
        endcase

        for (int i = 0; i < 16; i++) regs_d[i] = regs_q[i];
        if (rf_we) regs_d[rf_waddr] = rf_wdata;
    end

    // Outputs come from state flops only, so reset clears them immediately.
    always_comb begin
        imem_addr  = pc_q;
        dmem_req   = (state_q == S_MEM);
        dmem_we    = mem_we_q;
        dmem_addr  = mem_addr_q;
        dmem_wdata = mem_wdata_q;
        out_valid  = out_valid_q;
        out_data   = out_data_q;
        halted     = (state_q == S_HALT);
        carry      = carry_q;
    end

endmodule
